// File: rtl/oled_spi_driver.sv
// SSD1306 128x64 OLED driver: hard reset, init sequence, then one address window plus 1024 data bytes per frame over 4-wire SPI mode 0.
// Define OLED_INVERT_EN to add the invert input (per-frame inversion of data bytes).
module oled_spi_driver #(
   parameter int CLK_DIV      = 4,
   parameter int RESET_CYCLES = 1000,
   parameter int BOOT_CYCLES  = 1000,
   parameter int FRAME_GAP    = 0
) (
   input  logic       clk,
   input  logic       rst_n,
`ifdef OLED_INVERT_EN
   input  logic       invert,
`endif
   input  logic [7:0] data_in,
   output logic [9:0] byte_counter,
   output logic       sclk,
   output logic       mosi,
   output logic       cs_n,
   output logic       dc,
   output logic       res_n,
   output logic       frame_done
);

   typedef enum logic [2:0] {RST_HOLD, BOOT_WAIT, INIT, WINDOW, FETCH, SEND, GAP} state_e;

   localparam logic [7:0] INIT_SEQ [0:24] = '{
      8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
      8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
      8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
   localparam logic [7:0] WIN_SEQ [0:5] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

   // A byte is 18 CLK_DIV-long phases: 0 = dc setup with cs_n high, 1..16 = eight
   // low/high sclk halves, 17 = trailing low half before cs_n is released.
   localparam logic [4:0] LAST_PHASE = 5'd17;

   state_e      state_q;
   logic [31:0] cnt_q;
   logic [31:0] div_q;
   logic [4:0]  phase_q;
   logic [4:0]  idx_q;
   logic [7:0]  shift_q;
   logic [7:0]  data_q;
   logic [9:0]  byte_cnt_q;
   logic        sclk_q, mosi_q, cs_n_q, dc_q, res_n_q, frame_done_q;
`ifdef OLED_INVERT_EN
   logic        inv_q;
`endif

   logic [7:0]  cur_byte;
   logic        half_end;

   assign half_end = (div_q == 32'(CLK_DIV - 1));

   always_comb begin
      // NOTE: default first so every path assigns cur_byte and no latch is inferred.
      cur_byte = data_q;
      if (state_q == INIT)
         cur_byte = INIT_SEQ[idx_q];
      else if (state_q == WINDOW)
         cur_byte = WIN_SEQ[idx_q[2:0]];
   end

`ifdef OLED_INVERT_EN
   // Polarity is frozen on the first WINDOW cycle and held for the whole frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         inv_q <= 1'b0;
      else if (state_q == WINDOW && idx_q == '0 && phase_q == '0 && div_q == '0)
         inv_q <= invert;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RST_HOLD;
         cnt_q        <= '0;
         div_q        <= '0;
         phase_q      <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         byte_cnt_q   <= '0;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         cs_n_q       <= 1'b1;
         dc_q         <= 1'b0;
         res_n_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout so every register sees pre-edge values.
         frame_done_q <= 1'b0;
         case (state_q)
            RST_HOLD:
               if (cnt_q == 32'(RESET_CYCLES - 1)) begin
                  res_n_q <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= BOOT_WAIT;
               end else cnt_q <= cnt_q + 32'd1;
            BOOT_WAIT:
               if (cnt_q == 32'(BOOT_CYCLES - 1)) begin
                  cnt_q   <= '0;
                  state_q <= INIT;
               end else cnt_q <= cnt_q + 32'd1;
            GAP:
               if (cnt_q == 32'(FRAME_GAP - 1)) begin
                  cnt_q   <= '0;
                  state_q <= WINDOW;
               end else cnt_q <= cnt_q + 32'd1;
            FETCH:
               // Source answers one cycle after byte_counter moves; take it on the second.
               if (cnt_q == 32'd1) begin
                  cnt_q   <= '0;
`ifdef OLED_INVERT_EN
                  data_q  <= inv_q ? ~data_in : data_in;
`else
                  data_q  <= data_in;
`endif
                  dc_q    <= 1'b1;
                  state_q <= SEND;
               end else cnt_q <= cnt_q + 32'd1;
            default: begin
               if (!half_end) begin
                  div_q <= div_q + 32'd1;
               end else begin
                  div_q   <= '0;
                  phase_q <= phase_q + 5'd1;
                  if (phase_q == '0) begin
                     cs_n_q  <= 1'b0;
                     mosi_q  <= cur_byte[7];
                     shift_q <= {cur_byte[6:0], 1'b0};
                  end else if (phase_q == LAST_PHASE) begin
                     phase_q <= '0;
                     cs_n_q  <= 1'b1;
                     mosi_q  <= 1'b0;
                     case (state_q)
                        INIT:
                           if (idx_q == 5'd24) begin
                              idx_q   <= '0;
                              state_q <= WINDOW;
                           end else idx_q <= idx_q + 5'd1;
                        WINDOW:
                           if (idx_q == 5'd5) begin
                              idx_q   <= '0;
                              cnt_q   <= '0;
                              state_q <= FETCH;
                           end else idx_q <= idx_q + 5'd1;
                        default: begin
                           cnt_q <= '0;
                           if (byte_cnt_q == 10'd1023) begin
                              frame_done_q <= 1'b1;
                              byte_cnt_q   <= '0;
                              dc_q         <= 1'b0;
                              state_q      <= (FRAME_GAP == 0) ? WINDOW : GAP;
                           end else begin
                              byte_cnt_q <= byte_cnt_q + 10'd1;
                              state_q    <= FETCH;
                           end
                        end
                     endcase
                  end else if (phase_q[0]) begin
                     sclk_q <= 1'b1;
                  end else begin
                     sclk_q <= 1'b0;
                     if (phase_q != 5'd16) begin
                        mosi_q  <= shift_q[7];
                        shift_q <= {shift_q[6:0], 1'b0};
                     end
                  end
               end
            end
         endcase
      end
   end

   assign byte_counter = byte_cnt_q;
   assign sclk         = sclk_q;
   assign mosi         = mosi_q;
   assign cs_n         = cs_n_q;
   assign dc           = dc_q;
   assign res_n        = res_n_q;
   assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_oled_spi_driver.sv
// Scoreboard bench for oled_spi_driver: expected SPI bytes and frame_done markers are queued by the stimulus and popped by an SPI monitor.
`timescale 1ns/1ps
module tb_oled_spi_driver;

   localparam int CLK_DIV      = 2;
   localparam int RESET_CYCLES = 10;
   localparam int BOOT_CYCLES  = 5;
   localparam int FRAME_GAP    = 0;

   localparam logic [7:0] INIT_SEQ [25] = '{
      8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
      8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
      8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
   localparam logic [7:0] WIN_SEQ [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

   typedef struct packed {
      logic [3:0] bits;
      logic       fd;
      logic       dc;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [9:0] byte_counter;
   logic       sclk, mosi, cs_n, dc, res_n, frame_done;
`ifdef OLED_INVERT_EN
   logic       invert = 1'b0;
`endif

   oled_spi_driver #(
      .CLK_DIV(CLK_DIV), .RESET_CYCLES(RESET_CYCLES),
      .BOOT_CYCLES(BOOT_CYCLES), .FRAME_GAP(FRAME_GAP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef OLED_INVERT_EN
      .invert(invert),
`endif
      .data_in(data_in),
      .byte_counter(byte_counter),
      .sclk(sclk),
      .mosi(mosi),
      .cs_n(cs_n),
      .dc(dc),
      .res_n(res_n),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int  checks  = 0;
   int  errors  = 0;
   int  viol    = 0;
   int  fd_seen = 0;
   ev_t sb[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, expv, $time);
      end
   endtask

   task automatic push_byte(input logic dc_v, input logic [7:0] d);
      sb.push_back('{bits: 4'd8, fd: 1'b0, dc: dc_v, data: d});
   endtask

   task automatic push_cmds(input bit with_init);
      if (with_init)
         for (int i = 0; i < 25; i++) push_byte(1'b0, INIT_SEQ[i]);
      for (int i = 0; i < 6; i++) push_byte(1'b0, WIN_SEQ[i]);
   endtask

   task automatic push_data(input int n, input bit inv);
      for (int i = 0; i < n; i++) begin
         logic [7:0] d;
         d = 8'(i);
         if (inv) d = ~d;
         push_byte(1'b1, d);
      end
   endtask

   task automatic count_res_low(output int n);
      n = 0;
      while (!res_n && n < 1000) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Source model: the true byte (low 8 bits of the index) appears only in the
   // second cycle after cs_n rises (the edge byte_counter moves); otherwise a
   // neighbouring value, so early or late sampling is caught.
   int   src_age = 3;
   logic src_cs_prev = 1'b1;
   always @(posedge clk) begin
      #1;
      if (cs_n && !src_cs_prev) src_age = 0;
      else if (src_age < 3) src_age++;
      src_cs_prev = cs_n;
      data_in = (src_age == 1) ? byte_counter[7:0] : byte_counter[7:0] + 8'd1;
   end

   // SPI monitor and scoreboard consumer.
   logic       sclk_p = 1'b0, cs_p = 1'b1, mosi_p = 1'b0, byte_dc = 1'b0;
   logic [7:0] shreg = 8'h00;
   int         bit_cnt = 0;
   always @(negedge clk) begin
      ev_t got_e, exp_e;
      if (!rst_n) begin
         bit_cnt = 0;
         sclk_p  = 1'b0;
         cs_p    = 1'b1;
         mosi_p  = 1'b0;
      end else begin
         if (cs_n && cs_p && sclk != sclk_p) viol++;
         if (sclk && sclk_p && mosi != mosi_p) viol++;
         if (!cs_n && !cs_p && dc != byte_dc) viol++;
         if (!cs_n && cs_p) begin
            bit_cnt = 0;
            byte_dc = dc;
         end
         if (!cs_n && sclk && !sclk_p) begin
            shreg = {shreg[6:0], mosi};
            bit_cnt++;
         end
         if (cs_n && !cs_p) begin
            got_e = '{bits: 4'(bit_cnt), fd: 1'b0, dc: byte_dc, data: shreg};
            if (sb.size() > 0) exp_e = sb.pop_front();
            else exp_e = '1;
            check("spi_byte", 32'(got_e), 32'(exp_e));
         end
         if (frame_done) begin
            fd_seen++;
            got_e = '{bits: 4'd0, fd: 1'b1, dc: 1'b0, data: 8'h00};
            if (sb.size() > 0) exp_e = sb.pop_front();
            else exp_e = '1;
            check("frame_done", 32'(got_e), 32'(exp_e));
         end
         sclk_p = sclk;
         cs_p   = cs_n;
         mosi_p = mosi;
      end
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("reset_outputs", {sclk, mosi, cs_n, dc, res_n, frame_done, byte_counter},
            {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0});

      push_cmds(1'b1);
      push_data(1024, 1'b0);
      sb.push_back('{bits: 4'd0, fd: 1'b1, dc: 1'b0, data: 8'h00});
      push_cmds(1'b0);
`ifdef OLED_INVERT_EN
      push_data(1024, 1'b1);
`else
      push_data(1024, 1'b0);
`endif

      rst_n = 1'b1;
      count_res_low(n);
      check("res_n_low_cycles", 32'(n), 32'(RESET_CYCLES));
      n = 0;
      while (cs_n && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("boot_to_first_cs", 32'(n >= BOOT_CYCLES && n < 200), 32'd1);

`ifdef OLED_INVERT_EN
      n = 0;
      while (byte_counter != 10'd100 && n < 10000) begin
         @(negedge clk);
         n++;
      end
      check("reach_byte100", 32'(n < 10000), 32'd1);
      invert = 1'b1;
`endif

      n = 0;
      while (!(fd_seen == 1 && byte_counter == 10'd500 && !cs_n) && n < 70000) begin
         @(negedge clk);
         n++;
      end
      check("reach_frame2_byte500", 32'(n < 70000), 32'd1);

      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("midframe_reset", {sclk, mosi, cs_n, dc, res_n, frame_done, byte_counter},
               {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0});
      sb.delete();
`ifdef OLED_INVERT_EN
      invert = 1'b0;
`endif
      repeat (3) @(negedge clk);
      push_cmds(1'b1);
      push_data(4, 1'b0);
      rst_n = 1'b1;
      count_res_low(n);
      check("res_n_low_after_abort", 32'(n), 32'(RESET_CYCLES));

      n = 0;
      while (sb.size() > 0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      check("frame_done_count", 32'(fd_seen), 32'd1);
      check("protocol_violations", 32'(viol), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
